core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//  Sits directly downstream of the pipeline core: merges its instruction-bus and data-bus requests onto one
//  memory bus (single outstanding transaction). Latches the winning request, drives it until memory acknowledges,
//  then returns data on the matching response port. Includes fairness and a watchdog for a hung memory.
// PARAMETERS
//  MAX_D_STREAK  4     consecutive D grants allowed while I is waiting; then I gets priority once
//  TIMEOUT       1023  cycles in BUSY without cresp_ready before err is raised (0 disables watchdog)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  i_valid        in   1   instruction fetch request
//  i_addr         in   64  fetch address (4-byte aligned)
//  i_addr_ok      out  1   1-cycle pulse: fetch request accepted/latched
//  i_data_ok      out  1   1-cycle pulse: i_data valid
//  i_data         out  32  fetched instruction word
//  d_valid        in   1   data request
//  d_addr         in   64  data address
//  d_size         in   3   log2 bytes (0..3)
//  d_strobe       in   8   byte write enables; nonzero = write
//  d_wdata        in   64  write data
//  d_addr_ok      out  1   1-cycle pulse: data request accepted
//  d_data_ok      out  1   1-cycle pulse: d_rdata valid / write done
//  d_rdata        out  64  read data
//  c_valid        out  1   memory request valid
//  c_is_write     out  1   1 = write
//  c_addr         out  64  latched address
//  c_size         out  3   latched size (fetch: 3'd2)
//  c_strobe       out  8   latched strobe (fetch: 8'h00)
//  c_wdata        out  64  latched write data
//  c_ready        in   1   memory response / completion pulse
//  c_rdata        in   64  memory read data (valid with c_ready)
//  err            out  1   sticky watchdog error
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; all outputs 0; streak=0; wdog=0; err=0. Reset mid-transaction
//    abandons it; no data_ok issued afterwards; a late c_ready in IDLE is ignored.
//  - FSM: IDLE, BUSY_I, BUSY_D, RESP.
//    IDLE: if d_valid and (!i_valid or streak<MAX_D_STREAK) -> latch D fields, pulse d_addr_ok, BUSY_D;
//          else if i_valid -> latch i_addr, pulse i_addr_ok, BUSY_I. Both idle -> stay.
//    BUSY_x: c_valid=1, c_* from latch (stable until c_ready). On c_ready: capture c_rdata, -> RESP.
//    RESP: pulse x_data_ok for exactly 1 cycle with captured data; -> IDLE. Next grant earliest the cycle after.
//  - Latency: request seen in IDLE at cycle N -> addr_ok N, c_valid N+1.., data_ok 1 cycle after c_ready.
//  - Arbitration: D default priority. streak++ on each D grant while i_valid=1; cleared on any I grant or
//    D grant with i_valid=0. streak saturates at MAX_D_STREAK.
//  - i_data = addr_latched[2] ? c_rdata_latched[63:32] : [31:0]. d_rdata = full 64 bits unshifted.
//  - c_is_write = (latched d_strobe != 0) in BUSY_D; 0 in BUSY_I. c_* are 0 whenever c_valid=0.
//  - Request held across addr_ok: requester must drop/change valid after addr_ok; a still-asserted valid in
//    IDLE is treated as a new request.
//  - Watchdog: wdog counts cycles in BUSY_x, cleared on entry; at wdog==TIMEOUT set err (sticky until reset),
//    return to IDLE without data_ok. TIMEOUT=0: never fires.
//  - Simultaneous c_ready and reaching TIMEOUT: c_ready wins, no err.
//  - addr_ok and data_ok never both asserted in one cycle; at most one transaction outstanding.
// TESTING
//  1 Fetch only: i_valid, i_addr=0x8000_0004; c_ready after 3 cycles, c_rdata=0xAAAA_BBBB_CCCC_DDDD
//    -> i_addr_ok once, c_size=2, c_strobe=0, i_data_ok 1 cycle after c_ready, i_data=0xAAAA_BBBB.
//  2 Both valid in IDLE: d store addr 0x8000_1000 strobe 0xFF, wdata 0x1234 -> D granted first,
//    c_is_write=1, c_wdata=0x1234; I granted on next IDLE.
//  3 Fairness: d_valid and i_valid held high, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D...
//  4 Watchdog: TIMEOUT=15, c_ready never asserted -> err=1 at 16th BUSY cycle, state IDLE, no data_ok.
//  5 Reset at cycle 2 of BUSY_D, then c_ready pulse -> no d_data_ok, all outputs 0, err=0.
//  6 Load size 1 at 0x8000_0102 -> c_size=1, c_is_write=0, d_rdata equals c_rdata unshifted.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - merges core instruction and data requests onto one single-outstanding memory bus
module core_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [63:0] d_rdata,
    output logic        c_valid,
    output logic        c_is_write,
    output logic [63:0] c_addr,
    output logic [2:0]  c_size,
    output logic [7:0]  c_strobe,
    output logic [63:0] c_wdata,
    input  logic        c_ready,
    input  logic [63:0] c_rdata,
    output logic        err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int SW  = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [WDW-1:0] WDOG_MAX   = WDW'(TIMEOUT);

    logic [1:0]     r_state;
    logic           r_sel_d;
    logic [63:0]    r_addr;
    logic [2:0]     r_size;
    logic [7:0]     r_strobe;
    logic [63:0]    r_wdata;
    logic [63:0]    r_rdata;
    logic [SW-1:0]  r_streak;
    logic [WDW-1:0] r_wdog;
    logic           r_err;

    logic w_idle;
    logic w_busy;
    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;

    // Grants are combinational so addr_ok lands in the same cycle the request is seen in IDLE.
    assign w_idle    = (r_state == S_IDLE) && !reset;
    assign w_busy    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
    assign w_grant_d = w_idle && d_valid && (!i_valid || (r_streak < STREAK_MAX));
    assign w_grant_i = w_idle && i_valid && !w_grant_d;
    assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_MAX);

    assign i_addr_ok  = w_grant_i;
    assign d_addr_ok  = w_grant_d;
    assign i_data_ok  = (r_state == S_RESP) && !r_sel_d;
    assign d_data_ok  = (r_state == S_RESP) && r_sel_d;
    assign i_data     = !i_data_ok ? 32'd0 : (r_addr[2] ? r_rdata[63:32] : r_rdata[31:0]);
    assign d_rdata    = d_data_ok ? r_rdata : 64'd0;

    assign c_valid    = w_busy;
    assign c_is_write = (r_state == S_BUSY_D) && (r_strobe != 8'h00);
    assign c_addr     = w_busy ? r_addr   : 64'd0;
    assign c_size     = w_busy ? r_size   : 3'd0;
    assign c_strobe   = w_busy ? r_strobe : 8'h00;
    assign c_wdata    = w_busy ? r_wdata  : 64'd0;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel_d  <= 1'b0;
            r_addr   <= 64'd0;
            r_size   <= 3'd0;
            r_strobe <= 8'h00;
            r_wdata  <= 64'd0;
            r_rdata  <= 64'd0;
            r_streak <= '0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (w_grant_d) begin
                        r_state  <= S_BUSY_D;
                        r_sel_d  <= 1'b1;
                        r_addr   <= d_addr;
                        r_size   <= d_size;
                        r_strobe <= d_strobe;
                        r_wdata  <= d_wdata;
                        if (!i_valid)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end else if (w_grant_i) begin
                        r_state  <= S_BUSY_I;
                        r_sel_d  <= 1'b0;
                        r_addr   <= i_addr;
                        r_size   <= 3'd2;
                        r_strobe <= 8'h00;
                        r_wdata  <= 64'd0;
                        r_streak <= '0;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    // A response arriving on the timeout cycle still completes normally.
                    if (c_ready) begin
                        r_rdata <= c_rdata;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [63:0] d_rdata;
    logic        c_valid;
    logic        c_is_write;
    logic [63:0] c_addr;
    logic [2:0]  c_size;
    logic [7:0]  c_strobe;
    logic [63:0] c_wdata;
    logic        c_ready;
    logic [63:0] c_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    core_bus_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .c_valid(c_valid), .c_is_write(c_is_write), .c_addr(c_addr), .c_size(c_size),
        .c_strobe(c_strobe), .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called one cycle into BUSY; asserts c_ready on the n-th BUSY cycle and returns in RESP.
    task automatic mem_respond(input int n, input logic [63:0] rd);
        repeat (n - 1) @(negedge clk);
        c_ready = 1'b1;
        c_rdata = rd;
        @(negedge clk);
        c_ready = 1'b0;
        c_rdata = 64'd0;
        #1;
    endtask

    logic [1:0] exp_grant [6];
    int         busy_cnt;
    int         dok_seen;

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_addr = '0; d_valid = 1'b1; d_addr = '0;
        d_size = '0; d_strobe = '0; d_wdata = '0; c_ready = 1'b0; c_rdata = '0;
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b01; exp_grant[4] = 2'b10; exp_grant[5] = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        check("rst_c_valid", c_valid, 0);
        check("rst_err", err, 0);
        check("rst_d_addr_ok", d_addr_ok, 0);
        check("rst_data_ok", {i_data_ok, d_data_ok}, 0);

        // fetch only
        @(negedge clk);
        reset = 1'b0; d_valid = 1'b0; i_valid = 1'b1; i_addr = 64'h8000_0004;
        #1;
        check("t1_i_addr_ok", i_addr_ok, 1);
        check("t1_d_addr_ok", d_addr_ok, 0);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("t1_c_valid", c_valid, 1);
        check("t1_c_addr", c_addr, 64'h8000_0004);
        check("t1_c_size", c_size, 2);
        check("t1_c_strobe", c_strobe, 0);
        check("t1_c_is_write", c_is_write, 0);
        check("t1_i_addr_ok_once", i_addr_ok, 0);
        mem_respond(3, 64'hAAAA_BBBB_CCCC_DDDD);
        check("t1_i_data_ok", i_data_ok, 1);
        check("t1_i_data", i_data, 32'hAAAA_BBBB);
        check("t1_d_data_ok", d_data_ok, 0);
        check("t1_c_valid_resp", c_valid, 0);
        @(negedge clk);
        #1;
        check("t1_i_data_ok_pulse", i_data_ok, 0);

        // both valid: D wins, I follows on the next IDLE
        @(negedge clk);
        d_valid = 1'b1; d_addr = 64'h8000_1000; d_strobe = 8'hFF; d_wdata = 64'h1234; d_size = 3'd3;
        i_valid = 1'b1; i_addr = 64'h8000_0010;
        #1;
        check("t2_d_addr_ok", d_addr_ok, 1);
        check("t2_i_addr_ok", i_addr_ok, 0);
        @(negedge clk);
        d_valid = 1'b0;
        #1;
        check("t2_c_is_write", c_is_write, 1);
        check("t2_c_wdata", c_wdata, 64'h1234);
        check("t2_c_addr", c_addr, 64'h8000_1000);
        check("t2_c_strobe", c_strobe, 8'hFF);
        check("t2_no_grant_busy", {i_addr_ok, d_addr_ok}, 0);
        mem_respond(1, 64'h0);
        check("t2_d_data_ok", d_data_ok, 1);
        check("t2_no_grant_resp", i_addr_ok, 0);
        @(negedge clk);
        #1;
        check("t2_i_grant", i_addr_ok, 1);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("t2_i_c_addr", c_addr, 64'h8000_0010);
        mem_respond(2, 64'h5555_6666_7777_8888);
        check("t2_i_data", i_data, 32'h7777_8888);
        @(negedge clk);

        // fairness: both held high through six grants
        d_valid = 1'b1; i_valid = 1'b1; d_strobe = 8'h00; d_addr = 64'h8000_2000;
        for (int g = 0; g < 6; g++) begin
            #1;
            check($sformatf("t3_grant%0d", g), {i_addr_ok, d_addr_ok}, exp_grant[g]);
            @(negedge clk);
            c_ready = 1'b1;
            @(negedge clk);
            c_ready = 1'b0;
            #1;
            check($sformatf("t3_ok_excl%0d", g), (i_addr_ok | d_addr_ok) & (i_data_ok | d_data_ok), 0);
            @(negedge clk);
        end
        d_valid = 1'b0; i_valid = 1'b0;
        @(negedge clk);

        // load size 1
        d_valid = 1'b1; d_addr = 64'h8000_0102; d_size = 3'd1; d_strobe = 8'h00;
        #1;
        check("t6_d_addr_ok", d_addr_ok, 1);
        @(negedge clk);
        d_valid = 1'b0;
        #1;
        check("t6_c_size", c_size, 1);
        check("t6_c_is_write", c_is_write, 0);
        check("t6_c_addr", c_addr, 64'h8000_0102);
        mem_respond(2, 64'h1122_3344_5566_7788);
        check("t6_d_data_ok", d_data_ok, 1);
        check("t6_d_rdata", d_rdata, 64'h1122_3344_5566_7788);
        check("t6_i_data_ok", i_data_ok, 0);
        @(negedge clk);

        // watchdog: no c_ready
        i_valid = 1'b1; i_addr = 64'h8000_0040;
        #1;
        check("t4_i_addr_ok", i_addr_ok, 1);
        @(negedge clk);
        i_valid = 1'b0;
        busy_cnt = 0;
        dok_seen = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (i_data_ok || d_data_ok) dok_seen++;
            if (!c_valid) break;
            busy_cnt++;
            @(negedge clk);
        end
        check("t4_busy_cycles", busy_cnt, 16);
        check("t4_err", err, 1);
        check("t4_c_valid", c_valid, 0);
        repeat (3) @(negedge clk);
        #1;
        if (i_data_ok || d_data_ok) dok_seen++;
        check("t4_err_sticky", err, 1);
        @(negedge clk);
        c_ready = 1'b1; c_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        c_ready = 1'b0; c_rdata = 64'd0;
        #1;
        if (i_data_ok || d_data_ok) dok_seen++;
        check("t4_no_data_ok", dok_seen, 0);
        check("t4_late_ready_idle", c_valid, 0);

        // reset mid BUSY_D, then a stray c_ready
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_err_cleared", err, 0);
        @(negedge clk);
        d_valid = 1'b1; d_addr = 64'h8000_3000; d_strobe = 8'h0F; d_wdata = 64'h99;
        #1;
        check("t5_d_addr_ok", d_addr_ok, 1);
        @(negedge clk);
        d_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t5_busy2", c_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; c_ready = 1'b1; c_rdata = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("t5_c_valid", c_valid, 0);
        check("t5_c_fields", {c_addr, c_wdata} != 128'd0, 0);
        @(negedge clk);
        c_ready = 1'b0; c_rdata = 64'd0;
        #1;
        check("t5_no_d_data_ok", d_data_ok, 0);
        check("t5_d_rdata", d_rdata, 0);
        check("t5_err", err, 0);
        check("t5_c_valid_after", c_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule
